// File: rtl/ula_pkg.sv
// Shared definitions for the ALU front-end arbiter: opcodes, FSM states
// and the opcode legality check.
package ula_pkg;

    localparam logic [4:0] SOMA     = 5'b00000;
    localparam logic [4:0] SUBTRAI  = 5'b00001;
    localparam logic [4:0] MULT     = 5'b00010;
    localparam logic [4:0] DIV      = 5'b00011;
    localparam logic [4:0] DIVU     = 5'b00100;
    localparam logic [4:0] E_LOG    = 5'b00101;
    localparam logic [4:0] OU_LOG   = 5'b00110;
    localparam logic [4:0] XOU      = 5'b00111;
    localparam logic [4:0] NOU      = 5'b01000;
    localparam logic [4:0] DESL_E   = 5'b01001;
    localparam logic [4:0] DESL_D   = 5'b01010;
    localparam logic [4:0] DESL_A   = 5'b01011;
    localparam logic [4:0] MAIOR    = 5'b01110;
    localparam logic [4:0] SEGUIDOR = 5'b11111;

    typedef enum logic [1:0] {
        OCIOSO,
        ESPERA,
        CAPTURA,
        CONCLUI
    } estado_t;

    function automatic logic op_valida(input logic [4:0] op);
        return (op <= DESL_A) || (op == MAIOR) || (op == SEGUIDOR);
    endfunction

endpackage

// File: rtl/ula_arbitro_if.sv
// Requester-side and ALU-side signal bundle of the ALU arbiter.
interface ula_arbitro_if #(parameter int LARGURA = 32);

    logic               req0, req1;
    logic [4:0]         op0, op1;
    logic [LARGURA-1:0] rs0, rt0, rs1, rt1;
    logic               done0, done1, erro;
    logic [LARGURA-1:0] resultado, hi_reg, lo_reg;
    logic [4:0]         ula_op;
    logic [LARGURA-1:0] ula_rs, ula_rt;
    logic [LARGURA-1:0] ula_res, ula_hi, ula_lo;

    modport slave (
        input  req0, op0, rs0, rt0, req1, op1, rs1, rt1,
        input  ula_res, ula_hi, ula_lo,
        output done0, done1, erro, resultado, hi_reg, lo_reg,
        output ula_op, ula_rs, ula_rt
    );

    modport master (
        output req0, op0, rs0, rt0, req1, op1, rs1, rt1,
        output ula_res, ula_hi, ula_lo,
        input  done0, done1, erro, resultado, hi_reg, lo_reg,
        input  ula_op, ula_rs, ula_rt
    );

endinterface

// File: rtl/ula_rr_arb.sv
// Two-way round-robin grant; the pointer remembers who was served last.
module ula_rr_arb (
    input  logic clock,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic amostra_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // Reset to "1 served last" so requester 0 wins the first tie.
    logic ult_q;

    assign gnt0_o = amostra_i & req0_i & (~req1_i | ult_q);
    assign gnt1_o = amostra_i & req1_i & (~req0_i | ~ult_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ult_q <= 1'b1;
        else if (gnt0_o)
            ult_q <= 1'b0;
        else if (gnt1_o)
            ult_q <= 1'b1;
    end

endmodule

// File: rtl/ula_arbitro.sv
// Arbiter/sequencer in front of the shared ALU: grants, drives the ALU bus,
// waits the fixed ALU latency and returns the result with a done pulse.
module ula_arbitro
    import ula_pkg::*;
#(
    parameter int LARGURA = 32,
    parameter int ULA_LAT = 1
) (
    input  logic           clock,
    input  logic           reset,
    ula_arbitro_if.slave   bus
);

    localparam int CW = (ULA_LAT < 2) ? 1 : $clog2(ULA_LAT + 1);

    estado_t            estado_q;
    logic [CW-1:0]      cnt_q;
    logic               dono_q;
    logic               done0_q, done1_q, erro_q;
    logic [LARGURA-1:0] res_q, hi_q, lo_q;
    logic [4:0]         ula_op_q;
    logic [LARGURA-1:0] ula_rs_q, ula_rt_q;

    logic               gnt0, gnt1;
    logic [4:0]         op_sel;
    logic [LARGURA-1:0] rs_sel, rt_sel;
    logic               aceita;

    ula_rr_arb u_rr (
        .clock     (clock),
        .reset     (reset),
        .req0_i    (bus.req0),
        .req1_i    (bus.req1),
        .amostra_i (estado_q == OCIOSO),
        .gnt0_o    (gnt0),
        .gnt1_o    (gnt1)
    );

    always_comb begin
        op_sel = gnt1 ? bus.op1 : bus.op0;
        rs_sel = gnt1 ? bus.rs1 : bus.rs0;
        rt_sel = gnt1 ? bus.rt1 : bus.rt0;
        aceita = op_valida(op_sel) &&
                 !(((op_sel == DIV) || (op_sel == DIVU)) && (rt_sel == '0));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            dono_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            erro_q   <= 1'b0;
            res_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ula_op_q <= '0;
            ula_rs_q <= '0;
            ula_rt_q <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (gnt0 || gnt1) begin
                        dono_q <= gnt1;
                        if (aceita) begin
                            ula_op_q <= op_sel;
                            ula_rs_q <= rs_sel;
                            ula_rt_q <= rt_sel;
                            cnt_q    <= CW'(ULA_LAT);
                            estado_q <= ESPERA;
                        end else begin
                            // Rejects never touch the ALU bus.
                            erro_q   <= 1'b1;
                            res_q    <= '0;
                            done0_q  <= gnt0;
                            done1_q  <= gnt1;
                            estado_q <= CONCLUI;
                        end
                    end
                end
                ESPERA: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        estado_q <= CAPTURA;
                end
                CAPTURA: begin
                    res_q <= bus.ula_res;
                    if (ula_op_q == MULT) begin
                        hi_q <= bus.ula_hi;
                        lo_q <= bus.ula_lo;
                    end
                    erro_q   <= 1'b0;
                    done0_q  <= ~dono_q;
                    done1_q  <= dono_q;
                    estado_q <= CONCLUI;
                end
                CONCLUI: begin
                    done0_q  <= 1'b0;
                    done1_q  <= 1'b0;
                    estado_q <= OCIOSO;
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.erro      = erro_q;
    assign bus.resultado = res_q;
    assign bus.hi_reg    = hi_q;
    assign bus.lo_reg    = lo_q;
    assign bus.ula_op    = ula_op_q;
    assign bus.ula_rs    = ula_rs_q;
    assign bus.ula_rt    = ula_rt_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// Directed + random bench for ula_arbitro with a behavioural ALU and a
// transaction-level reference model.
module tb_ula_arbitro;
    import ula_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ula_arbitro_if #(.LARGURA(W)) bus ();

    ula_arbitro #(.LARGURA(W), .ULA_LAT(LAT)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ALU: returns {hi, lo, res}
    function automatic logic [3*W-1:0] alu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0] r, h, l;
        p = (2*W)'(a) * (2*W)'(b);
        r = '0; h = '0; l = '0;
        case (op)
            SOMA:     r = a + b;
            SUBTRAI:  r = a - b;
            MULT:     begin h = p[2*W-1:W]; l = p[W-1:0]; r = l; end
            DIV:      if (b != 0 && !(a == 32'h8000_0000 && b == '1)) begin
                          r = $signed(a) / $signed(b); l = r; h = $signed(a) % $signed(b);
                      end
            DIVU:     if (b != 0) begin r = a / b; l = r; h = a % b; end
            E_LOG:    r = a & b;
            OU_LOG:   r = a | b;
            XOU:      r = a ^ b;
            NOU:      r = ~(a | b);
            DESL_E:   r = a << b[4:0];
            DESL_D:   r = a >> b[4:0];
            DESL_A:   r = $signed(a) >>> b[4:0];
            MAIOR:    r = ($signed(a) > $signed(b)) ? 1 : 0;
            SEGUIDOR: r = a;
            default:  r = '0;
        endcase
        return {h, l, r};
    endfunction

    logic [3*W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= alu(bus.ula_op, bus.ula_rs, bus.ula_rt);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {bus.ula_hi, bus.ula_lo, bus.ula_res} = pipe[LAT-1];

    // reference model state
    logic [W-1:0] m_res, m_hi, m_lo, m_rs, m_rt;
    logic [4:0]   m_op;
    bit           m_ult;

    function automatic bit m_legal(input logic [4:0] op, input logic [W-1:0] rt);
        bit ok;
        ok = (op <= 5'd11) || (op == 5'd14) || (op == 5'd31);
        if ((op == 5'd3 || op == 5'd4) && rt == 0) ok = 0;
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_res = 0; m_hi = 0; m_lo = 0; m_rs = 0; m_rt = 0; m_op = 0; m_ult = 1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done0"}, 64'(bus.done0), 0);
        chk({tag, "_done1"}, 64'(bus.done1), 0);
        chk({tag, "_erro"}, 64'(bus.erro), 0);
        chk({tag, "_res"}, 64'(bus.resultado), 0);
        chk({tag, "_hi"}, 64'(bus.hi_reg), 0);
        chk({tag, "_lo"}, 64'(bus.lo_reg), 0);
        chk({tag, "_ula_op"}, 64'(bus.ula_op), 0);
        chk({tag, "_ula_rs"}, 64'(bus.ula_rs), 0);
        chk({tag, "_ula_rt"}, 64'(bus.ula_rt), 0);
    endtask

    task automatic drive(input int n, input bit rq, input logic [4:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
        if (n == 0) begin bus.req0 = rq; bus.op0 = op; bus.rs0 = rs; bus.rt0 = rt; end
        else        begin bus.req1 = rq; bus.op1 = op; bus.rs1 = rs; bus.rt1 = rt; end
    endtask

    // Single-requester transaction, req raised in cycle 0.
    task automatic txn(input int n, input logic [4:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt, input string tag);
        int k;
        bit ok, other, mine;
        logic [3*W-1:0] e;
        @(negedge clk);
        drive(n, 1, op, rs, rt);
        ok = m_legal(op, rt);
        other = 0; k = 0;
        do begin
            @(negedge clk);
            k++;
            other |= (n == 1) ? bus.done0 : bus.done1;
            mine = (n == 1) ? bus.done1 : bus.done0;
            if (k == 1 && ok) begin
                chk({tag, "_bus_op"}, 64'(bus.ula_op), 64'(op));
                chk({tag, "_bus_rs"}, 64'(bus.ula_rs), 64'(rs));
                chk({tag, "_bus_rt"}, 64'(bus.ula_rt), 64'(rt));
                drive(n, 1, op, ~rs, rt ^ 32'h5a5a_0001);
            end
        end while (!mine && k < 20);
        m_ult = n[0];
        if (ok) begin
            e = alu(op, rs, rt);
            m_res = e[W-1:0];
            if (op == MULT) begin m_hi = e[3*W-1:2*W]; m_lo = e[2*W-1:W]; end
            m_op = op; m_rs = rs; m_rt = rt;
        end else m_res = 0;
        chk({tag, "_latency"}, 64'(k), ok ? 64'(2 + LAT) : 64'd1);
        chk({tag, "_erro"}, 64'(bus.erro), 64'(!ok));
        chk({tag, "_res"}, 64'(bus.resultado), 64'(m_res));
        chk({tag, "_hi"}, 64'(bus.hi_reg), 64'(m_hi));
        chk({tag, "_lo"}, 64'(bus.lo_reg), 64'(m_lo));
        chk({tag, "_ula_op"}, 64'(bus.ula_op), 64'(m_op));
        chk({tag, "_other_done"}, 64'(other), 0);
        drive(n, 0, 0, 0, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus.done0 | bus.done1), 0);
        chk({tag, "_hold"}, 64'(bus.resultado), 64'(m_res));
    endtask

    // Both requesters held: 0 does 9-4, 1 does 8-3.
    task automatic cont(input int cnt);
        int k;
        bit got;
        @(negedge clk);
        drive(0, 1, SUBTRAI, 9, 4);
        drive(1, 1, SUBTRAI, 8, 3);
        for (int t = 0; t < cnt; t++) begin
            k = 0;
            do begin @(negedge clk); k++; end while (!(bus.done0 | bus.done1) && k < 20);
            chk("cont_timeout", 64'(k < 20), 1);
            chk("cont_both", 64'(bus.done0 & bus.done1), 0);
            got = bus.done1;
            chk("cont_order", 64'(got), 64'(!m_ult));
            chk("cont_res", 64'(bus.resultado), 5);
            chk("cont_erro", 64'(bus.erro), 0);
            m_ult = got; m_res = 5; m_op = SUBTRAI;
            if (t == cnt - 1) begin drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); end
        end
        @(negedge clk);
        chk("cont_idle", 64'(bus.done0 | bus.done1), 0);
    endtask

    initial begin
        bit seen;
        logic [4:0] legal_ops [14] = '{SOMA, SUBTRAI, MULT, DIV, DIVU, E_LOG, OU_LOG,
                                        XOU, NOU, DESL_E, DESL_D, DESL_A, MAIOR, SEGUIDOR};
        logic [4:0] op;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        txn(0, SOMA, 5, 7, "soma");
        txn(1, MULT, 32'h0001_0000, 32'h0001_0000, "mult");
        txn(0, DIV, 123, 0, "div0");
        txn(1, 5'b01100, 3, 2, "badop");
        txn(0, MAIOR, 3, 2, "maior");

        // reset while the multiply waits on the ALU
        @(negedge clk);
        drive(1, 1, MULT, 32'h1234_5678, 32'h9abc_def0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        repeat (4) begin @(negedge clk); seen |= bus.done0 | bus.done1; end
        chk("midrst_nodone", 64'(seen), 0);
        chk("midrst_hi", 64'(bus.hi_reg), 0);

        cont(4);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) op = 5'($urandom);
            else op = legal_ops[$urandom_range(0, 13)];
            txn(int'($urandom_range(0, 1)), op, $urandom,
                ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
